// File: rtl/mem_crypt_pkg.sv
// rtl/mem_crypt_pkg.sv - shared constants and state type for the memory cipher engine
package mem_crypt_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int KEY_W     = 16;
    localparam int LEN_W     = 11;
    localparam int MEM_WORDS = 1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        XFORM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/crypt_word_xform.sv
// rtl/crypt_word_xform.sv - combinational per-word cipher transform (xor with doubled key, rotate by key[4:0])
module crypt_word_xform
    import mem_crypt_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [KEY_W-1:0]  key,
    input  logic              decrypt,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0]   k_word;
    logic [4:0]          rot;
    logic [2*DATA_W-1:0] dbl_l;
    logic [2*DATA_W-1:0] dbl_r;

    // Encrypt xors then rotates left; decrypt undoes it by rotating right then xoring.
    // Rotation is done by shifting a doubled word so a zero rotate needs no special case.
    always_comb begin
        k_word = {key, key};
        rot    = key[4:0];
        dbl_l  = {x ^ k_word, x ^ k_word} << rot;
        dbl_r  = {x, x} >> rot;
        y      = decrypt ? (dbl_r[DATA_W-1:0] ^ k_word) : dbl_l[2*DATA_W-1:DATA_W];
    end

endmodule

// File: rtl/mem_crypt_engine.sv
// rtl/mem_crypt_engine.sv - block read/transform/write cipher engine mastering the 1K x 32 memory
module mem_crypt_engine
    import mem_crypt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              decrypt,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [KEY_W-1:0]  key
);

    state_t             state;
    logic [ADDR_W-1:0]  src_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [KEY_W-1:0]   key_q;
    logic               dec_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  xf_out;
    logic [LEN_W-1:0]   len_sat;
    logic [ADDR_W-1:0]  idx;

    // words_done doubles as the word index; address adds truncate, giving the 1023->0 wrap
    assign idx     = words_done[ADDR_W-1:0];
    assign len_sat = (len > LEN_W'(MEM_WORDS)) ? LEN_W'(MEM_WORDS) : len;

    crypt_word_xform u_xform (
        .x       (mem_read_data),
        .key     (key_q),
        .decrypt (dec_q),
        .y       (xf_out)
    );

    // Job sequencer: one word takes READ, XFORM, WRITE; parameters are frozen at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            key_q      <= '0;
            dec_q      <= 1'b0;
            data_q     <= '0;
            words_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= len_sat;
                        key_q      <= key;
                        dec_q      <= decrypt;
                        words_done <= '0;
                        state      <= (len_sat == '0) ? DONE : READ;
                    end
                end
                READ:  state <= XFORM;
                XFORM: begin
                    data_q <= xf_out;
                    state  <= WRITE;
                end
                WRITE: begin
                    words_done <= words_done + 1'b1;
                    state      <= ((words_done + 1'b1) == len_q) ? DONE : READ;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side outputs decode straight from state so reset drops mem_write without waiting for a clock
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        mem_write   = (state == WRITE);
        mem_address = '0;
        case (state)
            READ, XFORM: mem_address = src_q + idx;
            WRITE:       mem_address = dst_q + idx;
            default:     mem_address = '0;
        endcase
    end

    assign mem_write_data = data_q;

endmodule
